mips_single_cycle_system: RTL and testbench

Single-cycle 32-bit MIPS subset processor with its instruction and data memories, forming the top-level system block. One instruction completes per clock. Memory-bus signals and the current instruction are exported for observation by benches. The block sits at the top of the design, below only the testbench.

---
 rtl/mips_single_cycle_system_pkg.sv | 50 +++++
 rtl/controller.sv | 65 ++++++
 rtl/datapath.sv | 75 +++++++
 rtl/dmem.sv | 27 ++
 rtl/imem.sv | 19 +
 rtl/mips.sv | 36 +++
 rtl/regfile.sv | 29 ++
 rtl/mips_single_cycle_system.sv | 41 ++++
 tb/tb_mips_single_cycle_system.sv | 241 ++++++++++++++++++++++++
 9 files changed

// File: rtl/mips_single_cycle_system_pkg.sv
// Shared encodings for the single-cycle MIPS subset: opcodes, functs,
// ALU operation codes and the decoded control bundle.
package mips_single_cycle_system_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_J    = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_ctrl_e;

  typedef struct packed {
    logic      regwrite;
    logic      regdst;
    logic      alusrc;
    logic      branch;
    logic      memwrite;
    logic      memtoreg;
    logic      jump;
    alu_ctrl_e alu_ctrl;
  } ctrl_t;

  function automatic logic [XLEN-1:0] sign_ext(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/controller.sv
// Main decoder (opcode) plus ALU decoder (funct + ALUOp); unsupported encodings decode to a NOP.
module controller
  import mips_single_cycle_system_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output ctrl_t      ctrl_c_o
);

  aluop_e    aluop;
  alu_ctrl_e funct_alu;
  logic      funct_ok;

  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = ALU_ADD;
    case (funct_i)
      FN_ADD:  funct_alu = ALU_ADD;
      FN_SUB:  funct_alu = ALU_SUB;
      FN_AND:  funct_alu = ALU_AND;
      FN_OR:   funct_alu = ALU_OR;
      FN_SLT:  funct_alu = ALU_SLT;
      default: funct_ok  = 1'b0;
    endcase
  end

  always_comb begin
    ctrl_c_o          = '0;
    ctrl_c_o.alu_ctrl = ALU_ADD;
    aluop             = ALUOP_ADD;
    case (op_i)
      OP_R: begin
        ctrl_c_o.regwrite = funct_ok;
        ctrl_c_o.regdst   = 1'b1;
        aluop             = ALUOP_FUNCT;
      end
      OP_LW: begin
        ctrl_c_o.regwrite = 1'b1;
        ctrl_c_o.alusrc   = 1'b1;
        ctrl_c_o.memtoreg = 1'b1;
      end
      OP_SW: begin
        ctrl_c_o.alusrc   = 1'b1;
        ctrl_c_o.memwrite = 1'b1;
      end
      OP_BEQ: begin
        ctrl_c_o.branch = 1'b1;
        aluop           = ALUOP_SUB;
      end
      OP_ADDI: begin
        ctrl_c_o.regwrite = 1'b1;
        ctrl_c_o.alusrc   = 1'b1;
      end
      OP_J:    ctrl_c_o.jump = 1'b1;
      default: ;
    endcase

    case (aluop)
      ALUOP_SUB:   ctrl_c_o.alu_ctrl = ALU_SUB;
      ALUOP_FUNCT: ctrl_c_o.alu_ctrl = funct_alu;
      default:     ctrl_c_o.alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/datapath.sv
// Datapath: pc register, next-pc selection, register file, ALU and writeback muxes.
module datapath
  import mips_single_cycle_system_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  ctrl_t           ctrl_i,
  input  logic [XLEN-1:0] instr_i,
  input  logic [XLEN-1:0] readdata_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] aluout_c_o,
  output logic [XLEN-1:0] writedata_c_o
);

  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   pcplus4, pcbranch, pcjump;
  logic [XLEN-1:0]   signimm, srca, srcb, rd2, result, aluout;
  logic [REG_AW-1:0] wa;
  logic              zero;
  logic [6:0]        unused_bits;

  assign unused_bits = {instr_i[31:26], ctrl_i.memwrite};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= '0;
    else        pc_q <= pc_d;
  end

  assign signimm  = sign_ext(instr_i[15:0]);
  assign pcplus4  = pc_q + XLEN'(4);
  assign pcbranch = pcplus4 + {signimm[29:0], 2'b00};
  assign pcjump   = {pcplus4[31:28], instr_i[25:0], 2'b00};

  always_comb begin
    pc_d = pcplus4;
    if (ctrl_i.jump)                pc_d = pcjump;
    else if (ctrl_i.branch && zero) pc_d = pcbranch;
  end

  assign wa     = ctrl_i.regdst ? instr_i[15:11] : instr_i[20:16];
  assign result = ctrl_i.memtoreg ? readdata_i : aluout;

  regfile rf (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (ctrl_i.regwrite),
    .ra1_i   (instr_i[25:21]),
    .ra2_i   (instr_i[20:16]),
    .wa_i    (wa),
    .wd_i    (result),
    .rd1_c_o (srca),
    .rd2_c_o (rd2)
  );

  assign srcb = ctrl_i.alusrc ? signimm : rd2;

  // ALU: wrapping arithmetic, signed slt producing 0/1
  always_comb begin
    aluout = '0;
    case (ctrl_i.alu_ctrl)
      ALU_AND: aluout = srca & srcb;
      ALU_OR:  aluout = srca | srcb;
      ALU_ADD: aluout = srca + srcb;
      ALU_SUB: aluout = srca - srcb;
      ALU_SLT: aluout = {31'b0, ($signed(srca) < $signed(srcb))};
      default: aluout = '0;
    endcase
  end

  assign zero          = (aluout == '0);
  assign pc_o          = pc_q;
  assign aluout_c_o    = aluout;
  assign writedata_c_o = rd2;

endmodule

// File: rtl/dmem.sv
// Word-addressed data RAM: combinational read, clocked write, not cleared by reset.
module dmem
  import mips_single_cycle_system_pkg::*;
#(
  parameter int unsigned WORDS = 64
) (
  input  logic            clk,
  input  logic            we_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] wd_i,
  output logic [XLEN-1:0] rd_c_o
);

  localparam int unsigned AW = $clog2(WORDS);

  logic [XLEN-1:0] RAM [0:WORDS-1];
  logic            unused_addr;

  assign unused_addr = ^{addr_i[XLEN-1:AW+2], addr_i[1:0]};

  always_ff @(posedge clk) begin
    if (we_i) RAM[addr_i[AW+1:2]] <= wd_i;
  end

  assign rd_c_o = RAM[addr_i[AW+1:2]];

endmodule

// File: rtl/imem.sv
// Instruction ROM; contents are loaded from outside through the RAM array.
module imem
  import mips_single_cycle_system_pkg::*;
#(
  parameter int unsigned WORDS = 64
) (
  input  logic [XLEN-1:0] addr_i,
  output logic [XLEN-1:0] rd_c_o
);

  localparam int unsigned AW = $clog2(WORDS);

  logic [XLEN-1:0] RAM [0:WORDS-1];
  logic            unused_addr;

  assign unused_addr = ^{addr_i[XLEN-1:AW+2], addr_i[1:0]};
  assign rd_c_o      = RAM[addr_i[AW+1:2]];

endmodule

// File: rtl/mips.sv
// Single-cycle core: controller decoding the current instruction, datapath executing it.
module mips
  import mips_single_cycle_system_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] instr_i,
  input  logic [XLEN-1:0] readdata_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] aluout_c_o,
  output logic [XLEN-1:0] writedata_c_o,
  output logic            memwrite_c_o
);

  ctrl_t ctrl;

  controller c (
    .op_i     (instr_i[31:26]),
    .funct_i  (instr_i[5:0]),
    .ctrl_c_o (ctrl)
  );

  datapath dp (
    .clk           (clk),
    .rst_n         (rst_n),
    .ctrl_i        (ctrl),
    .instr_i       (instr_i),
    .readdata_i    (readdata_i),
    .pc_o          (pc_o),
    .aluout_c_o    (aluout_c_o),
    .writedata_c_o (writedata_c_o)
  );

  assign memwrite_c_o = ctrl.memwrite;

endmodule

// File: rtl/regfile.sv
// 32 x 32-bit register file: two combinational reads, one clocked write, $0 hardwired to zero.
module regfile
  import mips_single_cycle_system_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [REG_AW-1:0] ra1_i,
  input  logic [REG_AW-1:0] ra2_i,
  input  logic [REG_AW-1:0] wa_i,
  input  logic [XLEN-1:0]   wd_i,
  output logic [XLEN-1:0]   rd1_c_o,
  output logic [XLEN-1:0]   rd2_c_o
);

  logic [XLEN-1:0] rf [0:31];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf[REG_AW'(i)] <= '0;
    end else if (we_i && (wa_i != '0)) begin
      rf[wa_i] <= wd_i;
    end
  end

  assign rd1_c_o = (ra1_i == '0) ? '0 : rf[ra1_i];
  assign rd2_c_o = (ra2_i == '0) ? '0 : rf[ra2_i];

endmodule

// File: rtl/mips_single_cycle_system.sv
// Top-level system: single-cycle MIPS core with its instruction ROM and data RAM.
module mips_single_cycle_system #(
  parameter int unsigned IMEM_WORDS = 64,
  parameter int unsigned DMEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [31:0] dataadr,
  output logic        memwrite,
  output logic [31:0] instr
);

  logic [31:0] pc;

  mips mips (
    .clk           (clk),
    .rst_n         (rst),
    .instr_i       (instr),
    .readdata_i    (readdata),
    .pc_o          (pc),
    .aluout_c_o    (dataadr),
    .writedata_c_o (writedata),
    .memwrite_c_o  (memwrite)
  );

  imem #(.WORDS(IMEM_WORDS)) imem (
    .addr_i (pc),
    .rd_c_o (instr)
  );

  dmem #(.WORDS(DMEM_WORDS)) dmem (
    .clk    (clk),
    .we_i   (memwrite),
    .addr_i (dataadr),
    .wd_i   (writedata),
    .rd_c_o (readdata)
  );

endmodule

// File: tb/tb_mips_single_cycle_system.sv
// Self-checking bench: loads small programs into the ROM, queues expected
// architectural results and compares them as each instruction retires.
module tb_mips_single_cycle_system;

  logic        clk;
  logic        rst;
  logic [31:0] writedata, readdata, dataadr, instr;
  logic        memwrite;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  logic [31:0] exp_q [$];
  string       tag_q [$];
  logic [31:0] prog  [$];

  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;

  mips_single_cycle_system #(.IMEM_WORDS(64), .DMEM_WORDS(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .writedata (writedata),
    .readdata  (readdata),
    .dataadr   (dataadr),
    .memwrite  (memwrite),
    .instr     (instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd,
                                        input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
  endfunction

  function automatic logic [31:0] reg_peek(input int i);
    return dut.mips.dp.rf.rf[5'(i)];
  endfunction

  function automatic logic [31:0] pc_peek();
    return dut.mips.dp.pc_q;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] exp);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
  endtask

  task automatic sb_pop(input logic [31:0] got);
    string       t;
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      check("sb_underflow", 32'(exp_q.size()), 32'd1);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      check(t, got, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold reset, rewrite the ROM, and return at a falling edge still in reset.
  task automatic load_prog();
    rst = 1'b0;
    for (int i = 0; i < 64; i++) dut.imem.RAM[6'(i)] = 32'h0;
    foreach (prog[i]) dut.imem.RAM[6'(i)] = prog[i];
    repeat (2) @(negedge clk);
  endtask

  task automatic release_rst();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;

    // reset then addi
    prog = '{32'h20090005};
    load_prog();
    check("t1_rst_rf9", reg_peek(9), 32'd0);
    check("t1_rst_pc", pc_peek(), 32'd0);
    check("t1_rst_instr", instr, 32'h20090005);
    release_rst();
    sb_push("t1_addi_rf9", 32'd5);
    tick();
    sb_pop(reg_peek(9));

    // repeated add doubling
    prog = '{32'h20090005, 32'h01294820, 32'h01294820, 32'h01294820};
    load_prog();
    release_rst();
    for (int k = 0; k < 4; k++) begin
      sb_push($sformatf("t2_dbl%0d_rf9", k), 32'd5 << k);
      tick();
      sb_pop(reg_peek(9));
    end

    // wrap: 1 doubled 31 times, then sub/add across the signed boundary
    prog = '{32'h20090001};
    for (int k = 0; k < 31; k++) prog.push_back(rtype(9, 9, 9, F_ADD));
    prog.push_back(32'h200C0001);
    prog.push_back(rtype(9, 12, 11, F_SUB));
    prog.push_back(rtype(11, 12, 11, F_ADD));
    prog.push_back(rtype(9, 9, 9, F_ADD));
    load_prog();
    release_rst();
    sb_push("t2_pow31_rf9", 32'h8000_0000);
    repeat (32) tick();
    sb_pop(reg_peek(9));
    tick();
    sb_push("t2_sub_rf11", 32'h7FFF_FFFF);
    tick();
    sb_pop(reg_peek(11));
    sb_push("t2_addwrap_rf11", 32'h8000_0000);
    tick();
    sb_pop(reg_peek(11));
    sb_push("t2_wrap0_rf9", 32'h0);
    tick();
    sb_pop(reg_peek(9));

    // store / load
    prog = '{32'h20090005, 32'hAC090004, 32'h8C0A0004, 32'h8C0D0006};
    load_prog();
    release_rst();
    check("t3_addi_memwrite", 32'(memwrite), 32'd0);
    tick();
    check("t3_sw_memwrite", 32'(memwrite), 32'd1);
    check("t3_sw_dataadr", dataadr, 32'd4);
    check("t3_sw_writedata", writedata, 32'd5);
    tick();
    check("t3_lw_memwrite", 32'(memwrite), 32'd0);
    check("t3_lw_readdata", readdata, 32'd5);
    sb_push("t3_lw_rf10", 32'd5);
    tick();
    sb_pop(reg_peek(10));
    check("t3_lwu_dataadr", dataadr, 32'd6);
    sb_push("t3_lwu_rf13", 32'd5);
    tick();
    sb_pop(reg_peek(13));

    // branch skips one word, jump returns to 0
    prog = '{32'h20090001, 32'h10000001, 32'h200A0077, 32'h21290001, 32'h08000000};
    load_prog();
    release_rst();
    tick();
    check("t4_pc_at_beq", pc_peek(), 32'd4);
    sb_push("t4_beq_pc", 32'd12);
    tick();
    sb_pop(pc_peek());
    check("t4_beq_instr", instr, 32'h21290001);
    sb_push("t4_after_rf9", 32'd2);
    sb_push("t4_skip_rf10", 32'd0);
    tick();
    sb_pop(reg_peek(9));
    sb_pop(reg_peek(10));
    sb_push("t4_j_pc", 32'd0);
    tick();
    sb_pop(pc_peek());
    check("t4_j_instr", instr, 32'h20090001);

    // slt, logic ops, $0, NOP encodings, RAM survives reset
    prog = '{32'h2008FFFF, 32'h20090001, rtype(8, 9, 10, F_SLT), rtype(9, 8, 9, F_SLT),
             32'h20000007, rtype(8, 10, 12, F_AND), rtype(8, 10, 13, F_OR),
             rtype(8, 10, 14, 6'h21), 32'h3C100005, 32'h8C0F0004};
    load_prog();
    release_rst();
    repeat (2) tick();
    sb_push("t5_slt_neg_rf10", 32'd1);
    tick();
    sb_pop(reg_peek(10));
    sb_push("t5_slt_pos_rf9", 32'd0);
    tick();
    sb_pop(reg_peek(9));
    check("t5_addi0_dataadr", dataadr, 32'd7);
    sb_push("t5_zero_rf0", 32'd0);
    tick();
    sb_pop(reg_peek(0));
    sb_push("t5_and_rf12", 32'd1);
    tick();
    sb_pop(reg_peek(12));
    sb_push("t5_or_rf13", 32'hFFFF_FFFF);
    tick();
    sb_pop(reg_peek(13));
    check("t5_badfn_memwrite", 32'(memwrite), 32'd0);
    sb_push("t5_badfn_rf14", 32'd0);
    tick();
    sb_pop(reg_peek(14));
    sb_push("t5_badop_rf16", 32'd0);
    sb_push("t5_badop_pc", 32'd36);
    tick();
    sb_pop(reg_peek(16));
    sb_pop(pc_peek());
    sb_push("t5_persist_rf15", 32'd5);
    tick();
    sb_pop(reg_peek(15));

    // reset in the middle of a counting loop
    prog = '{32'h21290001, 32'h08000000};
    load_prog();
    release_rst();
    repeat (5) tick();
    check("t6_run_rf9", reg_peek(9), 32'd3);
    check("t6_run_pc", pc_peek(), 32'd4);
    #2;
    rst = 1'b0;
    #1;
    check("t6_async_rf9", reg_peek(9), 32'd0);
    check("t6_async_pc", pc_peek(), 32'd0);
    check("t6_async_instr", instr, 32'h21290001);
    repeat (2) @(negedge clk);
    release_rst();
    sb_push("t6_resume1_rf9", 32'd1);
    tick();
    sb_pop(reg_peek(9));
    sb_push("t6_resume2_rf9", 32'd2);
    repeat (2) tick();
    sb_pop(reg_peek(9));

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
